// File: rtl/row_col_pkg.sv
// Shared types and constant helpers for the row_col_mac_pipe streaming dot-product engine.
package row_col_pkg;

    localparam int unsigned SAT_CONST_WIDTH = 32'd128;

    typedef struct packed {
        logic valid;
        logic last;
    } stage_ctrl_t;

    function automatic int unsigned beats_per_row(input int unsigned size, input int unsigned lanes);
        return size / lanes;
    endfunction

    function automatic int unsigned beat_cnt_width(input int unsigned beats);
        if (beats > 32'd1) begin
            return int'($clog2(beats));
        end else begin
            return 32'd1;
        end
    endfunction

    // Largest representable accumulator value, right-aligned in SAT_CONST_WIDTH bits.
    function automatic logic [SAT_CONST_WIDTH-1:0] sat_max(input int unsigned width, input bit is_signed);
        logic [SAT_CONST_WIDTH-1:0] v;
        int unsigned ones;
        ones = is_signed ? (width - 32'd1) : width;
        v = '0;
        for (int unsigned i = 32'd0; i < SAT_CONST_WIDTH; i++) begin
            v[i] = (i < ones);
        end
        return v;
    endfunction

    function automatic logic [SAT_CONST_WIDTH-1:0] sat_min(input int unsigned width, input bit is_signed);
        logic [SAT_CONST_WIDTH-1:0] v;
        v = '0;
        if (is_signed && (width > 32'd0)) begin
            v[width - 32'd1] = 1'b1;
        end else begin
            v = '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/row_col_lane_adder.sv
// Registered LANES-input adder (stage S2): extends each lane product to ACC_WIDTH and sums them.
module row_col_lane_adder
    import row_col_pkg::*;
#(
    parameter int unsigned LANES         = 32'd4,
    parameter int unsigned PRODUCT_WIDTH = 32'd32,
    parameter int unsigned ACC_WIDTH     = 32'd40,
    parameter int          SIGNED        = 32'sd0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  stage_ctrl_t                      in_ctrl,
    input  logic [LANES*PRODUCT_WIDTH-1:0]   in_prod,
    output stage_ctrl_t                      out_ctrl,
    output logic [ACC_WIDTH-1:0]             out_sum
);

    logic [ACC_WIDTH-1:0] ext_s [LANES];
    logic [ACC_WIDTH-1:0] sum_s;

    for (genvar g = 0; g < LANES; g++) begin : g_ext
        if (SIGNED != 32'sd0) begin : g_signed
            assign ext_s[g] = ACC_WIDTH'($signed(in_prod[g*PRODUCT_WIDTH +: PRODUCT_WIDTH]));
        end else begin : g_unsigned
            assign ext_s[g] = ACC_WIDTH'(in_prod[g*PRODUCT_WIDTH +: PRODUCT_WIDTH]);
        end
    end

    // Lane sum, wrapping modulo 2^ACC_WIDTH.
    always_comb begin
        sum_s = '0;
        for (int unsigned i = 32'd0; i < LANES; i++) begin
            sum_s = sum_s + ext_s[i];
        end
    end

    // S2 register; holds while the output stage is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_ctrl <= '0;
            out_sum  <= '0;
        end else if (en) begin
            out_ctrl <= in_ctrl;
            out_sum  <= sum_s;
        end else begin
            out_ctrl <= out_ctrl;
            out_sum  <= out_sum;
        end
    end

endmodule

// File: rtl/row_col_mac_pipe.sv
// Pipelined streaming dot-product engine: S1 lane multiply, S2 lane sum, S3 accumulate/output.
// Optional accumulator saturation with sticky overflow flag: define ROW_COL_MAC_SAT_EN.
module row_col_mac_pipe
    import row_col_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32'd16,
    parameter int unsigned PRODUCT_WIDTH = 32'd32,
    parameter int unsigned ROW_COL_SIZE  = 32'd16,
    parameter int unsigned LANES         = 32'd4,
    parameter int unsigned ACC_WIDTH     = 32'd40,
    parameter int          SIGNED        = 32'sd0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_a,
    input  logic [LANES*DATA_WIDTH-1:0]   in_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_WIDTH-1:0]          out_y,
    output logic                          out_ovf
);

    localparam int unsigned BEATS     = beats_per_row(ROW_COL_SIZE, LANES);
    localparam int unsigned CNT_W     = beat_cnt_width(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 32'd1);
    localparam bit          IS_SIGNED = (SIGNED != 32'sd0);
    localparam int unsigned MSB       = ACC_WIDTH - 32'd1;

    logic                             stall_s;
    logic                             accept_s;
    logic                             last_s;
    logic [CNT_W-1:0]                 cnt_r;
    logic [LANES*PRODUCT_WIDTH-1:0]   prod_s;
    logic [LANES*PRODUCT_WIDTH-1:0]   prod_r;
    stage_ctrl_t                      s1_ctrl_r;
    stage_ctrl_t                      s2_ctrl;
    logic [ACC_WIDTH-1:0]             s2_sum;
    logic [ACC_WIDTH-1:0]             acc_r;
    logic [ACC_WIDTH-1:0]             acc_next_s;
    logic                             ovf_next_s;

    // A held result freezes the whole pipeline.
    assign stall_s  = out_valid && !out_ready;
    assign in_ready = !stall_s;
    assign accept_s = in_valid && !stall_s;
    assign last_s   = (cnt_r == LAST_BEAT);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [DATA_WIDTH-1:0]    a_l;
        logic [DATA_WIDTH-1:0]    b_l;
        logic [PRODUCT_WIDTH-1:0] a_x;
        logic [PRODUCT_WIDTH-1:0] b_x;
        assign a_l = in_a[g*DATA_WIDTH +: DATA_WIDTH];
        assign b_l = in_b[g*DATA_WIDTH +: DATA_WIDTH];
        if (IS_SIGNED) begin : g_signed
            assign a_x = {{(PRODUCT_WIDTH-DATA_WIDTH){a_l[DATA_WIDTH-1]}}, a_l};
            assign b_x = {{(PRODUCT_WIDTH-DATA_WIDTH){b_l[DATA_WIDTH-1]}}, b_l};
        end else begin : g_unsigned
            assign a_x = {{(PRODUCT_WIDTH-DATA_WIDTH){1'b0}}, a_l};
            assign b_x = {{(PRODUCT_WIDTH-DATA_WIDTH){1'b0}}, b_l};
        end
        // Extended operands make the truncated product correct for both signednesses.
        assign prod_s[g*PRODUCT_WIDTH +: PRODUCT_WIDTH] = a_x * b_x;
    end

    // Beat counter and S1 product/control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            prod_r    <= '0;
            s1_ctrl_r <= '0;
        end else if (!stall_s) begin
            s1_ctrl_r.valid <= accept_s;
            s1_ctrl_r.last  <= accept_s && last_s;
            if (accept_s) begin
                prod_r <= prod_s;
                cnt_r  <= last_s ? '0 : (cnt_r + CNT_W'(32'd1));
            end else begin
                prod_r <= prod_r;
                cnt_r  <= cnt_r;
            end
        end else begin
            cnt_r     <= cnt_r;
            prod_r    <= prod_r;
            s1_ctrl_r <= s1_ctrl_r;
        end
    end

    row_col_lane_adder #(
        .LANES         (LANES),
        .PRODUCT_WIDTH (PRODUCT_WIDTH),
        .ACC_WIDTH     (ACC_WIDTH),
        .SIGNED        (SIGNED)
    ) u_lane_adder (
        .clk      (clk),
        .rst      (rst),
        .en       (!stall_s),
        .in_ctrl  (s1_ctrl_r),
        .in_prod  (prod_r),
        .out_ctrl (s2_ctrl),
        .out_sum  (s2_sum)
    );

`ifdef ROW_COL_MAC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH, IS_SIGNED));
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH, IS_SIGNED));

    logic [ACC_WIDTH-1:0] sum_s;
    logic                 ovf_now_s;
    logic                 ovf_r;

    // Saturating accumulate: once clamped, the accumulator holds for the rest of the row.
    always_comb begin
        sum_s = acc_r + s2_sum;
        if (IS_SIGNED) begin
            ovf_now_s = (acc_r[MSB] == s2_sum[MSB]) && (sum_s[MSB] != acc_r[MSB]);
        end else begin
            ovf_now_s = (sum_s < acc_r);
        end
        if (ovf_r) begin
            acc_next_s = acc_r;
            ovf_next_s = 1'b1;
        end else if (ovf_now_s) begin
            acc_next_s = (IS_SIGNED && acc_r[MSB]) ? ACC_MIN : ACC_MAX;
            ovf_next_s = 1'b1;
        end else begin
            acc_next_s = sum_s;
            ovf_next_s = 1'b0;
        end
    end

    // Sticky overflow flag, cleared when a row completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (!stall_s && s2_ctrl.valid) begin
            ovf_r <= s2_ctrl.last ? 1'b0 : ovf_next_s;
        end else begin
            ovf_r <= ovf_r;
        end
    end
`else
    // Wrapping accumulate.
    always_comb begin
        acc_next_s = acc_r + s2_sum;
        ovf_next_s = 1'b0;
    end
`endif

    // S3: accumulator and output registers; a new result may load on the handshake edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r     <= '0;
            out_y     <= '0;
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (!stall_s) begin
            if (s2_ctrl.valid && s2_ctrl.last) begin
                acc_r     <= '0;
                out_y     <= acc_next_s;
                out_valid <= 1'b1;
                out_ovf   <= ovf_next_s;
            end else if (s2_ctrl.valid) begin
                acc_r     <= acc_next_s;
                out_y     <= '0;
                out_valid <= 1'b0;
                out_ovf   <= 1'b0;
            end else begin
                acc_r     <= acc_r;
                out_y     <= '0;
                out_valid <= 1'b0;
                out_ovf   <= 1'b0;
            end
        end else begin
            acc_r     <= acc_r;
            out_y     <= out_y;
            out_valid <= out_valid;
            out_ovf   <= out_ovf;
        end
    end

endmodule

// File: tb/tb_row_col_mac_pipe.sv
// Self-checking bench for row_col_mac_pipe: unsigned, signed and 32-bit-accumulator instances
// share one stimulus stream; expectations for the 32-bit instance follow ROW_COL_MAC_SAT_EN.
module tb_row_col_mac_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        ready_ctl;
    logic        rand_ready;
    logic        rand_bit;
    logic        out_ready;

    logic        rdy0, rdy1, rdy2;
    logic        v0, v1, v2;
    logic        ov0, ov1, ov2;
    logic [39:0] y0, y1;
    logic [31:0] y2;

    int checks = 0;
    int failures = 0;
    int pushed = 0;
    int delivered = 0;

    logic [15:0] row_a [16];
    logic [15:0] row_b [16];
    logic [39:0] q_y0 [$];
    logic [39:0] q_y1 [$];
    logic [31:0] q_y2 [$];
    logic        q_ov2 [$];

    assign out_ready = rand_ready ? rand_bit : ready_ctl;

    row_col_mac_pipe u_unsigned (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_a(in_a), .in_b(in_b),
        .out_valid(v0), .out_ready(out_ready), .out_y(y0), .out_ovf(ov0)
    );

    row_col_mac_pipe #(.SIGNED(1)) u_signed (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_a(in_a), .in_b(in_b),
        .out_valid(v1), .out_ready(out_ready), .out_y(y1), .out_ovf(ov1)
    );

    row_col_mac_pipe #(.ACC_WIDTH(32)) u_acc32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_a(in_a), .in_b(in_b),
        .out_valid(v2), .out_ready(out_ready), .out_y(y2), .out_ovf(ov2)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial forever begin
        @(negedge clk);
        #1;
        rand_bit = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain dot products of the row, plus the 32-bit accumulator's per-beat behaviour.
    task automatic push_expect();
        longint unsigned su, acc32, ls;
        longint          ss;
        bit              ov;
        su = 0; ss = 0; acc32 = 0; ov = 1'b0;
        for (int bt = 0; bt < 4; bt++) begin
            ls = 0;
            for (int l = 0; l < 4; l++) begin
                su += longint'(row_a[bt*4+l]) * longint'(row_b[bt*4+l]);
                ss += longint'($signed(row_a[bt*4+l])) * longint'($signed(row_b[bt*4+l]));
                ls += longint'(row_a[bt*4+l]) * longint'(row_b[bt*4+l]);
            end
            ls = ls % 64'h1_0000_0000;
`ifdef ROW_COL_MAC_SAT_EN
            if (!ov) begin
                if (acc32 + ls > 64'hFFFF_FFFF) begin
                    ov = 1'b1;
                    acc32 = 64'hFFFF_FFFF;
                end else begin
                    acc32 = acc32 + ls;
                end
            end
`else
            acc32 = (acc32 + ls) % 64'h1_0000_0000;
`endif
        end
        q_y0.push_back(su[39:0]);
        q_y1.push_back(ss[39:0]);
        q_y2.push_back(acc32[31:0]);
        q_ov2.push_back(ov);
        pushed++;
    endtask

    // Result monitor: evaluated just before the edge on which a handshake would occur.
    always @(negedge clk) begin
        #2;
        if (!rst && v0 && out_ready) begin
            chk("result_expected", 64'(q_y0.size() != 0), 64'd1);
            if (q_y0.size() != 0) begin
                chk("res_y_unsigned", 64'(y0), 64'(q_y0.pop_front()));
                chk("res_y_signed", 64'(y1), 64'(q_y1.pop_front()));
                chk("res_y_acc32", 64'(y2), 64'(q_y2.pop_front()));
                chk("res_ovf_acc32", 64'(ov2), 64'(q_ov2.pop_front()));
                chk("res_ovf_unsigned", 64'(ov0), 64'd0);
                chk("res_ovf_signed", 64'(ov1), 64'd0);
                chk("res_valid_align", 64'({v1, v2}), 64'd3);
                delivered++;
            end
        end
    end

    task automatic load_beat(input int bt);
        for (int l = 0; l < 4; l++) begin
            in_a[l*16 +: 16] = row_a[bt*4+l];
            in_b[l*16 +: 16] = row_b[bt*4+l];
        end
    endtask

    // Present one beat and wait (bounded) for acceptance; returns just after the accepting edge.
    task automatic send_beat(input int bt);
        bit ok;
        load_beat(bt);
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            #2;
            ok = rdy0;
            @(posedge clk);
            #1;
        end
        chk("beat_accept", 64'(ok), 64'd1);
    endtask

    // gap_mode: 0 contiguous, 1 one idle cycle between beats, 2 random 0..2 idle cycles.
    task automatic send_row(input int gap_mode);
        for (int bt = 0; bt < 4; bt++) begin
            int gap;
            gap = (bt == 0) ? 0 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : gap_mode;
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(bt);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int t;
        t = 0;
        while (!v0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(tag, 64'(v0), 64'd1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_y2;
        logic        exp_o2;
        int          t;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        ready_ctl = 1'b1; rand_ready = 1'b0; rand_bit = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        chk("rst_out_valid", 64'(v0), 64'd0);
        chk("rst_out_y", 64'(y0), 64'd0);
        chk("rst_out_ovf", 64'(ov0), 64'd0);
        chk("rst_in_ready", 64'(rdy0), 64'd1);
        chk("rst_out_y_acc32", 64'(y2), 64'd0);

        // a = 1..16, b = 2, contiguous: latency and value.
        for (int e = 0; e < 16; e++) begin
            row_a[e] = 16'(e + 1);
            row_b[e] = 16'd2;
        end
        push_expect();
        send_row(0);
        chk("lat_edge0", 64'(v0), 64'd0);
        next_cycle();
        chk("lat_edge1", 64'(v0), 64'd0);
        next_cycle();
        chk("lat_edge2_valid", 64'(v0), 64'd1);
        chk("lat_y", 64'(y0), 64'd272);
        chk("lat_ovf", 64'(ov0), 64'd0);
        next_cycle();
        chk("clear_after_hs_valid", 64'(v0), 64'd0);
        chk("clear_after_hs_y", 64'(y0), 64'd0);

        // Signed operands: -3 * 5 over 16 elements.
        for (int e = 0; e < 16; e++) begin
            row_a[e] = 16'hFFFD;
            row_b[e] = 16'd5;
        end
        push_expect();
        send_row(0);
        wait_out("signed_wait");
        chk("signed_y", 64'(y1), 64'hFF_FFFF_FF10);
        chk("signed_ovf", 64'(ov1), 64'd0);
        next_cycle();

        // Backpressure across two back-to-back rows.
        ready_ctl = 1'b0;
        for (int e = 0; e < 16; e++) begin
            row_a[e] = 16'(e + 1);
            row_b[e] = 16'd2;
        end
        push_expect();
        send_row(0);
        for (int e = 0; e < 16; e++) begin
            row_a[e] = 16'd0;
            row_b[e] = 16'd0;
        end
        push_expect();
        send_beat(0);
        send_beat(1);
        load_beat(2);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #2;
            chk("stall_in_ready", 64'(rdy0), 64'd0);
            chk("stall_hold_valid", 64'(v0), 64'd1);
            chk("stall_hold_y", 64'(y0), 64'd272);
            next_cycle();
        end
        ready_ctl = 1'b1;
        send_beat(2);
        send_beat(3);
        in_valid = 1'b0;
        wait_out("bp_second_wait");
        chk("bp_second_y", 64'(y0), 64'd0);
        next_cycle();

        // Bubbles on every other cycle.
        for (int e = 0; e < 16; e++) begin
            row_a[e] = 16'(e + 1);
            row_b[e] = 16'd2;
        end
        push_expect();
        send_row(1);
        wait_out("bubble_wait");
        chk("bubble_y", 64'(y0), 64'd272);
        next_cycle();

        // Reset after two beats, then a row of ones.
        for (int e = 0; e < 16; e++) begin
            row_a[e] = 16'd7;
            row_b[e] = 16'd9;
        end
        send_beat(0);
        send_beat(1);
        in_valid = 1'b0;
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        chk("midrow_rst_valid", 64'(v0), 64'd0);
        chk("midrow_rst_ready", 64'(rdy0), 64'd1);
        for (int e = 0; e < 16; e++) begin
            row_a[e] = 16'd1;
            row_b[e] = 16'd1;
        end
        push_expect();
        send_row(0);
        wait_out("midrow_wait");
        chk("midrow_y", 64'(y0), 64'd16);
        chk("midrow_y_acc32", 64'(y2), 64'd16);
        next_cycle();

        // Full-scale operands on the 32-bit accumulator.
`ifdef ROW_COL_MAC_SAT_EN
        exp_y2 = 32'hFFFF_FFFF;
        exp_o2 = 1'b1;
`else
        exp_y2 = 32'hFFE0_0010;
        exp_o2 = 1'b0;
`endif
        for (int e = 0; e < 16; e++) begin
            row_a[e] = 16'hFFFF;
            row_b[e] = 16'hFFFF;
        end
        push_expect();
        send_row(0);
        wait_out("acc32_wait");
        chk("acc32_y", 64'(y2), 64'(exp_y2));
        chk("acc32_ovf", 64'(ov2), 64'(exp_o2));
        next_cycle();

        // Random rows, random bubbles, random consumer readiness.
        rand_ready = 1'b1;
        for (int r = 0; r < 24; r++) begin
            for (int e = 0; e < 16; e++) begin
                row_a[e] = 16'($urandom);
                row_b[e] = 16'($urandom);
            end
            push_expect();
            send_row(2);
        end
        rand_ready = 1'b0;
        ready_ctl = 1'b1;
        t = 0;
        while (q_y0.size() != 0 && t < 200) begin
            next_cycle();
            t++;
        end
        chk("drain_empty", 64'(q_y0.size()), 64'd0);
        chk("delivered_count", 64'(delivered), 64'(pushed));
        next_cycle();
        chk("idle_valid", 64'(v0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
